// File: rtl/dimm_cmd_responder.sv
// DIMM command responder: tracks 32 banks (open flag, open row, tRCD timer),
// checks ACT/RD/PRE/PREA legality, and plays back fixed-latency read bursts
// whose payload encodes the address that produced them.
module dimm_cmd_responder #(
    parameter int unsigned TRCD = 4,
    parameter int unsigned TCL  = 6,
    parameter int unsigned BL   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_bg,
    input  logic [1:0]  cmd_ba,
    input  logic [15:0] cmd_row,
    input  logic [5:0]  cmd_col,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic [5:0]  open_banks,
    output logic [15:0] rd_count
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ACT  = 3'd1;
    localparam logic [2:0] OP_RD   = 3'd2;
    localparam logic [2:0] OP_PRE  = 3'd3;
    localparam logic [2:0] OP_PREA = 3'd4;

    localparam logic [2:0] ERR_ACT_OPEN   = 3'd1;
    localparam logic [2:0] ERR_RD_CLOSED  = 3'd2;
    localparam logic [2:0] ERR_RD_TRCD    = 3'd3;
    localparam logic [2:0] ERR_PRE_CLOSED = 3'd4;
    localparam logic [2:0] ERR_BAD_OP     = 3'd5;

    // Timer saturates at TRCD; a bank is RD-ready once it reaches that value.
    localparam logic [7:0] TRCD_C    = 8'(TRCD);
    // Output beats are registered, so the first beat appears TCL-1 edges
    // after the accepting edge; the wait counter covers the remaining edges.
    localparam logic [5:0] CL_WAIT   = 6'(TCL - 2);
    localparam logic [3:0] LAST_BEAT = 4'(BL - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_CL = 2'd1,
        ST_BURST   = 2'd2
    } state_e;

    state_e       state_q, state_d;

    logic [31:0]  bank_open_q, bank_open_d;
    logic [15:0]  bank_row_q [32];
    logic [15:0]  bank_row_d [32];
    logic [7:0]   trcd_cnt_q [32];
    logic [7:0]   trcd_cnt_d [32];

    logic [4:0]   lat_idx_q, lat_idx_d;
    logic [15:0]  lat_row_q, lat_row_d;
    logic [5:0]   lat_col_q, lat_col_d;
    logic [5:0]   wait_q, wait_d;
    logic [3:0]   beat_q, beat_d;

    logic         rd_valid_q, rd_valid_d;
    logic         rd_last_q, rd_last_d;
    logic [31:0]  rd_data_q, rd_data_d;
    logic         err_valid_q, err_valid_d;
    logic [2:0]   err_code_q, err_code_d;
    logic [5:0]   open_banks_q, open_banks_d;
    logic [15:0]  rd_count_q, rd_count_d;

    logic         accept_s;
    logic         start_burst_s;
    logic [4:0]   cmd_idx_s;

    // Beat payload: {0, bank group, bank, row, column, beat index}.
    function automatic logic [31:0] beat_word(input logic [4:0]  idx,
                                              input logic [15:0] row,
                                              input logic [5:0]  col,
                                              input logic [3:0]  beat);
        return {1'b0, idx, row, col, beat};
    endfunction

    assign cmd_ready  = rst_n & (state_q == ST_IDLE);
    assign accept_s   = cmd_valid & cmd_ready;
    assign cmd_idx_s  = {cmd_bg, cmd_ba};

    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_last_q;
    assign rd_data    = rd_data_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign open_banks = open_banks_q;
    assign rd_count   = rd_count_q;

    // Bank table update, tRCD timers and command legality checking.
    always_comb begin
        bank_open_d   = bank_open_q;
        bank_row_d    = bank_row_q;
        open_banks_d  = open_banks_q;
        err_valid_d   = 1'b0;
        err_code_d    = 3'd0;
        start_burst_s = 1'b0;
        lat_idx_d     = lat_idx_q;
        lat_row_d     = lat_row_q;
        lat_col_d     = lat_col_q;

        for (int i = 0; i < 32; i++) begin
            if (bank_open_q[i] && (trcd_cnt_q[i] < TRCD_C)) begin
                trcd_cnt_d[i] = trcd_cnt_q[i] + 8'd1;
            end else begin
                trcd_cnt_d[i] = trcd_cnt_q[i];
            end
        end

        if (accept_s) begin
            case (cmd_op)
                OP_NOP: begin
                    err_valid_d = 1'b0;
                end
                OP_ACT: begin
                    if (bank_open_q[cmd_idx_s]) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_ACT_OPEN;
                    end else begin
                        bank_open_d[cmd_idx_s] = 1'b1;
                        bank_row_d[cmd_idx_s]  = cmd_row;
                        trcd_cnt_d[cmd_idx_s]  = 8'd1;
                        open_banks_d           = open_banks_q + 6'd1;
                    end
                end
                OP_RD: begin
                    if (!bank_open_q[cmd_idx_s]) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_RD_CLOSED;
                    end else if (trcd_cnt_q[cmd_idx_s] < TRCD_C) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_RD_TRCD;
                    end else begin
                        start_burst_s = 1'b1;
                        lat_idx_d     = cmd_idx_s;
                        lat_row_d     = bank_row_q[cmd_idx_s];
                        lat_col_d     = cmd_col;
                    end
                end
                OP_PRE: begin
                    if (!bank_open_q[cmd_idx_s]) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_PRE_CLOSED;
                    end else begin
                        bank_open_d[cmd_idx_s] = 1'b0;
                        trcd_cnt_d[cmd_idx_s]  = 8'd0;
                        open_banks_d           = open_banks_q - 6'd1;
                    end
                end
                OP_PREA: begin
                    bank_open_d  = 32'd0;
                    open_banks_d = 6'd0;
                    for (int i = 0; i < 32; i++) begin
                        trcd_cnt_d[i] = 8'd0;
                    end
                end
                default: begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_BAD_OP;
                end
            endcase
        end else begin
            start_burst_s = 1'b0;
        end
    end

    // Burst FSM: next state, beat sequencing and registered read outputs.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        beat_d     = beat_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_data_d  = 32'd0;
        rd_count_d = rd_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start_burst_s) begin
                    state_d = ST_WAIT_CL;
                    wait_d  = CL_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_CL: begin
                if (wait_q == 6'd0) begin
                    state_d    = ST_BURST;
                    beat_d     = 4'd0;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (LAST_BEAT == 4'd0);
                    rd_data_d  = beat_word(lat_idx_q, lat_row_q, lat_col_q, 4'd0);
                end else begin
                    wait_d = wait_q - 6'd1;
                end
            end
            ST_BURST: begin
                if (beat_q == LAST_BEAT) begin
                    state_d    = ST_IDLE;
                    rd_count_d = rd_count_q + 16'd1;
                end else begin
                    beat_d     = beat_q + 4'd1;
                    rd_valid_d = 1'b1;
                    rd_last_d  = ((beat_q + 4'd1) == LAST_BEAT);
                    rd_data_d  = beat_word(lat_idx_q, lat_row_q, lat_col_q, beat_q + 4'd1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Burst FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bank table, burst datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_open_q  <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                bank_row_q[i] <= 16'd0;
                trcd_cnt_q[i] <= 8'd0;
            end
            lat_idx_q    <= 5'd0;
            lat_row_q    <= 16'd0;
            lat_col_q    <= 6'd0;
            wait_q       <= 6'd0;
            beat_q       <= 4'd0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_data_q    <= 32'd0;
            err_valid_q  <= 1'b0;
            err_code_q   <= 3'd0;
            open_banks_q <= 6'd0;
            rd_count_q   <= 16'd0;
        end else begin
            bank_open_q  <= bank_open_d;
            bank_row_q   <= bank_row_d;
            trcd_cnt_q   <= trcd_cnt_d;
            lat_idx_q    <= lat_idx_d;
            lat_row_q    <= lat_row_d;
            lat_col_q    <= lat_col_d;
            wait_q       <= wait_d;
            beat_q       <= beat_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            rd_data_q    <= rd_data_d;
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
            open_banks_q <= open_banks_d;
            rd_count_q   <= rd_count_d;
        end
    end

endmodule

// File: tb/tb_dimm_cmd_responder.sv
// Self-checking bench for dimm_cmd_responder: directed command sequences,
// an edge-indexed behavioural model, a per-cycle compare process and a few
// hand-computed literal expectations.
module tb_dimm_cmd_responder;

    localparam int TRCD = 4;
    localparam int TCL  = 6;
    localparam int BL   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [2:0]  cmd_bg = 3'd0;
    logic [1:0]  cmd_ba = 2'd0;
    logic [15:0] cmd_row = 16'd0;
    logic [5:0]  cmd_col = 6'd0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [5:0]  open_banks;
    logic [15:0] rd_count;

    dimm_cmd_responder #(.TRCD(TRCD), .TCL(TCL), .BL(BL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_bg     (cmd_bg),
        .cmd_ba     (cmd_ba),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .open_banks (open_banks),
        .rd_count   (rd_count)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit run_chk   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (edge-indexed) ----------------
    int          cyc;          // number of rising edges since reset release
    bit          m_open [32];
    int          m_act  [32];  // edge index of the bank's last ACT
    logic [15:0] m_row  [32];
    bit          m_busy;
    int          m_rd;         // edge index of the accepted RD
    logic [4:0]  m_idx;
    logic [15:0] m_brow;
    logic [5:0]  m_col;
    bit          m_err;
    logic [2:0]  m_code;
    logic [15:0] m_cnt;
    bit          m_acc;

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 32; i++) begin
            m_open[i] = 1'b0;
            m_act[i]  = 0;
            m_row[i]  = 16'd0;
        end
        m_busy = 1'b0;
        m_rd   = 0;
        m_idx  = 5'd0;
        m_brow = 16'd0;
        m_col  = 6'd0;
        m_err  = 1'b0;
        m_code = 3'd0;
        m_cnt  = 16'd0;
        m_acc  = 1'b0;
    endtask

    task automatic flag(input logic [2:0] code);
        m_err  = 1'b1;
        m_code = code;
    endtask

    // Applies one rising edge to the model using the inputs present at it.
    task automatic model_update();
        bit rdy;
        int idx;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rdy = !m_busy;
        cyc++;
        m_err  = 1'b0;
        m_code = 3'd0;
        m_acc  = 1'b0;
        if (m_busy && (cyc - m_rd == TCL + BL - 1)) begin
            m_busy = 1'b0;
            m_cnt  = m_cnt + 16'd1;
        end
        if (cmd_valid && rdy) begin
            m_acc = 1'b1;
            idx   = int'({cmd_bg, cmd_ba});
            case (cmd_op)
                3'd0: m_acc = 1'b1;
                3'd1: begin
                    if (m_open[idx]) flag(3'd1);
                    else begin
                        m_open[idx] = 1'b1;
                        m_row[idx]  = cmd_row;
                        m_act[idx]  = cyc;
                    end
                end
                3'd2: begin
                    if (!m_open[idx]) flag(3'd2);
                    else if (cyc - m_act[idx] < TRCD) flag(3'd3);
                    else begin
                        m_busy = 1'b1;
                        m_rd   = cyc;
                        m_idx  = {cmd_bg, cmd_ba};
                        m_brow = m_row[idx];
                        m_col  = cmd_col;
                    end
                end
                3'd3: begin
                    if (!m_open[idx]) flag(3'd4);
                    else m_open[idx] = 1'b0;
                end
                3'd4: begin
                    for (int i = 0; i < 32; i++) m_open[i] = 1'b0;
                end
                default: flag(3'd5);
            endcase
        end
    endtask

    function automatic bit exp_valid();
        int k;
        k = cyc - m_rd;
        return m_busy && (k >= TCL - 1) && (k <= TCL + BL - 2);
    endfunction

    function automatic bit exp_last();
        return exp_valid() && (cyc - m_rd == TCL + BL - 2);
    endfunction

    function automatic logic [31:0] exp_data();
        int k;
        k = cyc - m_rd - (TCL - 1);
        if (exp_valid()) return {1'b0, m_idx, m_brow, m_col, 4'(k)};
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_open();
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_open[i]);
        return 32'(n);
    endfunction

    // Per-cycle comparison of every output against the model, mid-cycle.
    always @(posedge clk) begin
        #4;
        if (run_chk) begin
            chk("cmd_ready",  {31'd0, cmd_ready},  {31'd0, rst_n & !m_busy});
            chk("rd_valid",   {31'd0, rd_valid},   {31'd0, exp_valid()});
            chk("rd_last",    {31'd0, rd_last},    {31'd0, exp_last()});
            chk("rd_data",    rd_data,             exp_data());
            chk("err_valid",  {31'd0, err_valid},  {31'd0, m_err});
            chk("err_code",   {29'd0, err_code},   {29'd0, m_code});
            chk("open_banks", {26'd0, open_banks}, exp_open());
            chk("rd_count",   {16'd0, rd_count},   {16'd0, m_cnt});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] bg, input logic [1:0] ba,
                        input logic [15:0] row, input logic [5:0] col);
        cmd_op    = op;
        cmd_bg    = bg;
        cmd_ba    = ba;
        cmd_row   = row;
        cmd_col   = col;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    int wait_n;

    initial begin
        model_reset();
        run_chk = 1'b1;
        rst_n   = 1'b0;
        repeat (3) step();
        chk("rst_ready_low", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rd_data",   rd_data, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // Basic ACT -> RD with TRCD met exactly.
        send(3'd1, 3'd2, 2'd1, 16'h1234, 6'd0);
        idle(3);
        send(3'd2, 3'd2, 2'd1, 16'h0000, 6'h05);
        idle(TCL - 1);
        chk("beat0_valid", {31'd0, rd_valid}, 32'd1);
        chk("beat0_data",  rd_data, 32'h2448_D050);
        chk("model_beat0", exp_data(), 32'h2448_D050);
        idle(BL - 1);
        chk("last_flag", {31'd0, rd_last}, 32'd1);
        chk("last_data", rd_data, 32'h2448_D057);
        idle(1);
        chk("count_one",   {16'd0, rd_count}, 32'd1);
        chk("ready_again", {31'd0, cmd_ready}, 32'd1);

        // RD one cycle before TRCD, then re-ACT of the still-open bank.
        send(3'd1, 3'd1, 2'd0, 16'hBEEF, 6'd0);
        idle(2);
        send(3'd2, 3'd1, 2'd0, 16'h0000, 6'd3);
        chk("trcd_err_code", {29'd0, err_code}, 32'd3);
        idle(TCL + BL);
        send(3'd1, 3'd1, 2'd0, 16'h0001, 6'd0);
        chk("act_open_code", {29'd0, err_code}, 32'd1);
        send(3'd2, 3'd7, 2'd3, 16'h0000, 6'd0);
        chk("rd_closed_code", {29'd0, err_code}, 32'd2);
        send(3'd6, 3'd0, 2'd0, 16'h0000, 6'd0);
        chk("bad_op_code", {29'd0, err_code}, 32'd5);
        send(3'd7, 3'd0, 2'd0, 16'h0000, 6'd0);
        send(3'd0, 3'd0, 2'd0, 16'h0000, 6'd0);

        // Open all 32 banks, PREA, then PRE to a closed bank.
        send(3'd4, 3'd0, 2'd0, 16'h0000, 6'd0);
        for (int i = 0; i < 32; i++) begin
            send(3'd1, 3'(i >> 2), 2'(i & 3), 16'(i * 273), 6'd0);
        end
        chk("all_open", {26'd0, open_banks}, 32'd32);
        send(3'd4, 3'd0, 2'd0, 16'h0000, 6'd0);
        chk("prea_zero", {26'd0, open_banks}, 32'd0);
        send(3'd3, 3'd0, 2'd0, 16'h0000, 6'd0);
        chk("pre_closed_code", {29'd0, err_code}, 32'd4);

        // PRE then re-ACT restarts the TRCD timer.
        send(3'd1, 3'd3, 2'd2, 16'hA5A5, 6'd0);
        idle(10);
        send(3'd3, 3'd3, 2'd2, 16'h0000, 6'd0);
        send(3'd1, 3'd3, 2'd2, 16'h5A5A, 6'd0);
        idle(2);
        send(3'd2, 3'd3, 2'd2, 16'h0000, 6'd9);
        chk("reopen_trcd_code", {29'd0, err_code}, 32'd3);
        send(3'd2, 3'd3, 2'd2, 16'h0000, 6'h3F);
        idle(TCL - 1);
        chk("reopen_beat0", rd_data, 32'h3969_6BF0);
        idle(BL);
        chk("count_two", {16'd0, rd_count}, 32'd2);

        // Command held valid across a burst is taken only once ready returns.
        send(3'd2, 3'd3, 2'd2, 16'h0000, 6'd1);
        cmd_op    = 3'd1;
        cmd_bg    = 3'd4;
        cmd_ba    = 2'd0;
        cmd_row   = 16'h0F0F;
        cmd_col   = 6'd0;
        cmd_valid = 1'b1;
        wait_n    = 0;
        while (wait_n < 50) begin
            step();
            wait_n++;
            if (m_acc) break;
        end
        cmd_valid = 1'b0;
        chk("held_wait", 32'(wait_n), 32'(TCL + BL));
        idle(1);
        chk("held_open", {26'd0, open_banks}, 32'd2);

        // Reset asserted at beat 3 of a burst.
        idle(TRCD);
        send(3'd2, 3'd4, 2'd0, 16'h0000, 6'd2);
        idle(TCL - 1 + 3);
        chk("beat3_data", rd_data, 32'h403C_3C23);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_valid", {31'd0, rd_valid}, 32'd0);
        chk("abort_open",  {26'd0, open_banks}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
        chk("abort_count", {16'd0, rd_count}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        #1;
        chk("ready_after_abort", {31'd0, cmd_ready}, 32'd1);
        idle(TCL + BL);
        chk("no_count_after_abort", {16'd0, rd_count}, 32'd0);

        run_chk = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
